// File: rtl/axi4_lite_csr_master.sv
// axi4_lite_csr_master: single-outstanding AXI4-Lite initiator behind a cmd/rsp handshake port pair.
// Define CSR_MASTER_TIMEOUT_EN to enable the per-bus-state watchdog (TIMEOUT_CYCLES).
module axi4_lite_csr_master #(
   parameter logic [31:0] BASE_ADDR      = 32'h0,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_addr_i,
   input  logic [31:0] cmd_wdata_i,
   input  logic [3:0]  cmd_wstrb_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic [1:0]  rsp_resp_o,
   output logic        rsp_timeout_o,
   output logic        busy_o,
   output logic        csr_awvalid,
   input  logic        csr_awready,
   output logic [31:0] csr_awaddr,
   output logic [2:0]  csr_awprot,
   output logic        csr_wvalid,
   input  logic        csr_wready,
   output logic [31:0] csr_wdata,
   output logic [3:0]  csr_wstrb,
   input  logic        csr_bvalid,
   output logic        csr_bready,
   input  logic [1:0]  csr_bresp,
   output logic        csr_arvalid,
   input  logic        csr_arready,
   output logic [31:0] csr_araddr,
   output logic [2:0]  csr_arprot,
   input  logic        csr_rvalid,
   output logic        csr_rready,
   input  logic [31:0] csr_rdata,
   input  logic [1:0]  csr_rresp
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR      = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_ADDR = 3'd3;
   localparam logic [2:0] S_RD_DATA = 3'd4;
   localparam logic [2:0] S_RSP     = 3'd5;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("TIMEOUT_CYCLES must be nonzero");
   end

   logic [1:0]  rst_sync;
   logic        rst_n;
   logic [2:0]  state, state_d;
   logic [31:0] addr_q;
   logic        accept, wr_done, to_hit, tmo, rsp_enter;

   // async assert, sync deassert
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rst_sync <= 2'b00;
      else rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign csr_awaddr = addr_q;
   assign csr_araddr = addr_q;
   assign csr_awprot = 3'b000;
   assign csr_arprot = 3'b000;
   assign busy_o     = state != S_IDLE;
   assign accept     = cmd_valid_i && cmd_ready_o;
   assign rsp_enter  = state_d == S_RSP && state != S_RSP;

   always_comb begin
      wr_done = (!csr_awvalid || csr_awready) && (!csr_wvalid || csr_wready);
      tmo = to_hit && ((state == S_WR && !wr_done) || (state == S_WR_RESP && !csr_bvalid) ||
                       (state == S_RD_ADDR && !csr_arready) || (state == S_RD_DATA && !csr_rvalid));
      state_d = state;
      case (state)
         S_IDLE:    state_d = accept ? (cmd_we_i ? S_WR : S_RD_ADDR) : S_IDLE;
         S_WR:      state_d = wr_done ? S_WR_RESP : tmo ? S_RSP : S_WR;
         S_WR_RESP: state_d = (csr_bvalid || tmo) ? S_RSP : S_WR_RESP;
         S_RD_ADDR: state_d = csr_arready ? S_RD_DATA : tmo ? S_RSP : S_RD_ADDR;
         S_RD_DATA: state_d = (csr_rvalid || tmo) ? S_RSP : S_RD_DATA;
         S_RSP:     state_d = rsp_ready_i ? S_IDLE : S_RSP;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cmd_ready_o <= 1'b0;
         addr_q      <= '0;
         csr_wdata   <= '0;
         csr_wstrb   <= '0;
         csr_awvalid <= 1'b0;
         csr_wvalid  <= 1'b0;
         csr_arvalid <= 1'b0;
         csr_bready  <= 1'b0;
         csr_rready  <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_resp_o  <= '0;
      end else begin
         state       <= state_d;
         cmd_ready_o <= state_d == S_IDLE;
         if (accept) begin
            addr_q    <= BASE_ADDR + cmd_addr_i;
            csr_wdata <= cmd_wdata_i;
            csr_wstrb <= cmd_wstrb_i;
         end
         csr_awvalid <= accept ? cmd_we_i : csr_awvalid && !csr_awready && !tmo;
         csr_wvalid  <= accept ? cmd_we_i : csr_wvalid && !csr_wready && !tmo;
         csr_arvalid <= accept ? !cmd_we_i : csr_arvalid && !csr_arready && !tmo;
         csr_bready  <= state_d == S_WR_RESP;
         csr_rready  <= state_d == S_RD_DATA;
         rsp_valid_o <= state_d == S_RSP;
         if (rsp_enter) begin
            rsp_resp_o  <= tmo ? 2'b10 : state == S_WR_RESP ? csr_bresp : csr_rresp;
            rsp_rdata_o <= (state == S_RD_DATA && !tmo) ? csr_rdata : '0;
         end
      end
   end

`ifdef CSR_MASTER_TIMEOUT_EN
   logic [31:0] cnt;
   assign to_hit = cnt == TIMEOUT_CYCLES - 1;
   // counter restarts on every state change, so each bus state gets a full window
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         rsp_timeout_o <= 1'b0;
      end else begin
         cnt <= (state_d != state) ? '0 : cnt + 1;
         if (rsp_enter) rsp_timeout_o <= tmo;
      end
   end
`else
   assign to_hit        = 1'b0;
   assign rsp_timeout_o = 1'b0;
`endif
endmodule
